// File: rtl/div_unit.sv
// Iterative radix-2 restoring divider, signed or unsigned, with sign fix-up.
// Latency DW+1 cycles (1 cycle for a zero divisor); result is held while start_i stays high.
module div_unit #(
   parameter int DW = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            signed_div_i,
   input  logic [DW-1:0]   opdata1_i,
   input  logic [DW-1:0]   opdata2_i,
   input  logic            start_i,
   input  logic            annul_i,
   output logic [2*DW-1:0] result_o,
   output logic            ready_o,
   output logic            busy_o
);

   localparam int CW = $clog2(DW + 1);

   typedef enum logic [1:0] {
      IDLE,
      BYZERO,
      ON,
      END
   } state_t;

   state_t          state;
   logic [CW-1:0]   cnt;
   logic [2*DW:0]   pr;
   logic [DW-1:0]   divisor;
   logic            neg_q;
   logic            neg_r;

   logic [DW-1:0]   dividend_mag;
   logic [DW-1:0]   divisor_mag;
   logic [2*DW:0]   pr_sh;
   logic [DW+1:0]   trial;
   logic [2*DW:0]   pr_nxt;
   logic [DW-1:0]   q_raw;
   logic [DW-1:0]   r_raw;
   logic [DW-1:0]   q_fix;
   logic [DW-1:0]   r_fix;

   always_comb begin
      dividend_mag = (signed_div_i && opdata1_i[DW-1]) ? -opdata1_i : opdata1_i;
      divisor_mag  = (signed_div_i && opdata2_i[DW-1]) ? -opdata2_i : opdata2_i;
   end

   // Trial subtract on the shifted upper DW+1 bits; the extra top bit of pr
   // acts as the bit shifted out, so trial[DW+1] is the borrow.
   always_comb begin
      pr_sh  = {pr[2*DW-1:0], 1'b0};
      trial  = pr[2*DW:DW-1] - {2'b00, divisor};
      pr_nxt = pr_sh;
      if (!trial[DW+1]) begin
         pr_nxt = {trial[DW:0], pr_sh[DW-1:1], 1'b1};
      end
   end

   always_comb begin
      q_raw = pr[DW-1:0];
      r_raw = pr[2*DW-1:DW];
      q_fix = neg_q ? -q_raw : q_raw;
      r_fix = neg_r ? -r_raw : r_raw;
   end

   assign busy_o = (state != IDLE);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= IDLE;
         cnt      <= '0;
         pr       <= '0;
         divisor  <= '0;
         neg_q    <= 1'b0;
         neg_r    <= 1'b0;
         result_o <= '0;
         ready_o  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               ready_o  <= 1'b0;
               result_o <= '0;
               if (start_i && !annul_i) begin
                  pr      <= {{(DW+1){1'b0}}, dividend_mag};
                  divisor <= divisor_mag;
                  neg_q   <= signed_div_i & (opdata1_i[DW-1] ^ opdata2_i[DW-1]);
                  neg_r   <= signed_div_i & opdata1_i[DW-1];
                  cnt     <= '0;
                  state   <= (opdata2_i == '0) ? BYZERO : ON;
               end
            end
            BYZERO: begin
               result_o <= '0;
               if (annul_i) begin
                  ready_o <= 1'b0;
                  state   <= IDLE;
               end else begin
                  ready_o <= 1'b1;
                  state   <= END;
               end
            end
            ON: begin
               if (annul_i) begin
                  ready_o  <= 1'b0;
                  result_o <= '0;
                  state    <= IDLE;
               end else if (cnt == CW'(DW)) begin
                  result_o <= {r_fix, q_fix};
                  ready_o  <= 1'b1;
                  state    <= END;
               end else begin
                  pr  <= pr_nxt;
                  cnt <= cnt + CW'(1);
               end
            end
            END: begin
               // Flushes are ignored here; the EX stage releases us by dropping start_i.
               if (!start_i) begin
                  ready_o  <= 1'b0;
                  result_o <= '0;
                  state    <= IDLE;
               end
            end
            default: begin
               ready_o  <= 1'b0;
               result_o <= '0;
               state    <= IDLE;
            end
         endcase
      end
   end

endmodule
